// File: rtl/bin2seg_fmt.sv
// Binary to eight 7-segment digit patterns via iterative double-dabble plus one encode cycle.
// Define BIN2SEG_LZB_EN to enable leading-zero blanking of digits 7..1.
module bin2seg_fmt #(
    parameter int unsigned WIDTH = 27
) (
    input  logic             iCLK,
    input  logic             nRST,
    input  logic             iLOAD,
    input  logic [WIDTH-1:0] iVALUE,
    input  logic [7:0]       iDP,
    output logic             oBUSY,
    output logic             oDONE,
    output logic [7:0]       oSEG7,
    output logic [7:0]       oSEG6,
    output logic [7:0]       oSEG5,
    output logic [7:0]       oSEG4,
    output logic [7:0]       oSEG3,
    output logic [7:0]       oSEG2,
    output logic [7:0]       oSEG1,
    output logic [7:0]       oSEG0
);

    typedef enum logic [1:0] {StIdle, StShift, StEncode} stateT;

    localparam int unsigned CntW = 6;
    localparam logic [63:0] MaxShown = 64'd99_999_999;
    localparam logic [7:0]  DashPat  = 8'b0000_0010;

    stateT             stateQ, stateD;
    logic [WIDTH-1:0]  shiftQ, shiftD;
    logic [31:0]       bcdQ, bcdD, bcdAdj;
    logic [CntW-1:0]   cntQ, cntD;
    logic [7:0]        dpQ, dpD;
    logic              ovfQ, ovfD;
    logic              doneQ, doneD;
    logic [7:0][7:0]   segQ, segD, segNew;

    function automatic logic [6:0] encodeDigit(input logic [3:0] nib);
        case (nib)
            4'd0:    encodeDigit = 7'b1111110;
            4'd1:    encodeDigit = 7'b0110000;
            4'd2:    encodeDigit = 7'b1101101;
            4'd3:    encodeDigit = 7'b1111001;
            4'd4:    encodeDigit = 7'b0110011;
            4'd5:    encodeDigit = 7'b1011011;
            4'd6:    encodeDigit = 7'b1011111;
            4'd7:    encodeDigit = 7'b1110000;
            4'd8:    encodeDigit = 7'b1111111;
            4'd9:    encodeDigit = 7'b1111011;
            default: encodeDigit = 7'b0000000;
        endcase
    endfunction

    // Add-3 correction applied to every nibble before the shift.
    always_comb begin
        bcdAdj = '0;
        for (int i = 0; i < 8; i++) begin
            if (bcdQ[4*i +: 4] >= 4'd5) begin
                bcdAdj[4*i +: 4] = bcdQ[4*i +: 4] + 4'd3;
            end else begin
                bcdAdj[4*i +: 4] = bcdQ[4*i +: 4];
            end
        end
    end

    // Walk from the leftmost digit so the blanking run stops at the first nonzero nibble.
    always_comb begin
        logic [3:0] nib;
        logic [6:0] pat;
`ifdef BIN2SEG_LZB_EN
        logic       leadZero;
        leadZero = 1'b1;
`endif
        nib    = '0;
        pat    = '0;
        segNew = '0;
        for (int n = 7; n >= 0; n--) begin
            nib = bcdQ[4*n +: 4];
            pat = encodeDigit(nib);
`ifdef BIN2SEG_LZB_EN
            if (n != 0) begin
                leadZero = leadZero && (nib == 4'd0);
                if (leadZero) begin
                    pat = 7'b0000000;
                end
            end
`endif
            segNew[n] = ovfQ ? DashPat : {pat, dpQ[n]};
        end
    end

    always_comb begin
        stateD = stateQ;
        shiftD = shiftQ;
        bcdD   = bcdQ;
        cntD   = cntQ;
        dpD    = dpQ;
        ovfD   = ovfQ;
        doneD  = 1'b0;
        segD   = segQ;
        case (stateQ)
            StIdle: begin
                if (iLOAD) begin
                    shiftD = iVALUE;
                    dpD    = iDP;
                    bcdD   = '0;
                    cntD   = '0;
                    ovfD   = {{(64-WIDTH){1'b0}}, iVALUE} > MaxShown;
                    stateD = StShift;
                end
            end
            StShift: begin
                // Bits shifted out of the top nibble are lost; only reachable with ovf set.
                bcdD   = {bcdAdj[30:0], shiftQ[WIDTH-1]};
                shiftD = {shiftQ[WIDTH-2:0], 1'b0};
                cntD   = cntQ + CntW'(1);
                if (cntQ == CntW'(WIDTH - 1)) begin
                    stateD = StEncode;
                end
            end
            StEncode: begin
                segD   = segNew;
                doneD  = 1'b1;
                stateD = StIdle;
            end
            default: stateD = StIdle;
        endcase
    end

    always_ff @(posedge iCLK or negedge nRST) begin
        if (!nRST) begin
            stateQ <= StIdle;
            shiftQ <= '0;
            bcdQ   <= '0;
            cntQ   <= '0;
            dpQ    <= '0;
            ovfQ   <= 1'b0;
            doneQ  <= 1'b0;
            segQ   <= '0;
        end else begin
            stateQ <= stateD;
            shiftQ <= shiftD;
            bcdQ   <= bcdD;
            cntQ   <= cntD;
            dpQ    <= dpD;
            ovfQ   <= ovfD;
            doneQ  <= doneD;
            segQ   <= segD;
        end
    end

    assign oBUSY = (stateQ != StIdle);
    assign oDONE = doneQ;
    assign oSEG7 = segQ[7];
    assign oSEG6 = segQ[6];
    assign oSEG5 = segQ[5];
    assign oSEG4 = segQ[4];
    assign oSEG3 = segQ[3];
    assign oSEG2 = segQ[2];
    assign oSEG1 = segQ[1];
    assign oSEG0 = segQ[0];

endmodule

// File: tb/tb_bin2seg_fmt.sv
// Directed self-checking bench for bin2seg_fmt; expectations follow BIN2SEG_LZB_EN when defined.
module tb_bin2seg_fmt;

    localparam int unsigned W = 27;
`ifdef BIN2SEG_LZB_EN
    localparam bit Lzb = 1'b1;
`else
    localparam bit Lzb = 1'b0;
`endif

    logic         iCLK = 1'b0;
    logic         nRST = 1'b0;
    logic         iLOAD = 1'b0;
    logic [W-1:0] iVALUE = '0;
    logic [7:0]   iDP = '0;
    logic         oBUSY, oDONE;
    logic [7:0]   oSEG7, oSEG6, oSEG5, oSEG4, oSEG3, oSEG2, oSEG1, oSEG0;
    logic [7:0]   seg [8];
    logic [7:0]   exp [8];

    int checks = 0;
    int errors = 0;

    bin2seg_fmt #(.WIDTH(W)) dut (
        .iCLK(iCLK), .nRST(nRST), .iLOAD(iLOAD), .iVALUE(iVALUE), .iDP(iDP),
        .oBUSY(oBUSY), .oDONE(oDONE),
        .oSEG7(oSEG7), .oSEG6(oSEG6), .oSEG5(oSEG5), .oSEG4(oSEG4),
        .oSEG3(oSEG3), .oSEG2(oSEG2), .oSEG1(oSEG1), .oSEG0(oSEG0)
    );

    always #5 iCLK = ~iCLK;

    assign seg[0] = oSEG0;
    assign seg[1] = oSEG1;
    assign seg[2] = oSEG2;
    assign seg[3] = oSEG3;
    assign seg[4] = oSEG4;
    assign seg[5] = oSEG5;
    assign seg[6] = oSEG6;
    assign seg[7] = oSEG7;

    // Pattern a leading zero digit should show.
    function automatic logic [7:0] lead(input logic [7:0] shown);
        return Lzb ? {7'b0, shown[0]} : shown;
    endfunction

    // Drive a one-cycle load; returns #1 after the accepting edge.
    task automatic loadVal(input logic [W-1:0] v, input logic [7:0] dp);
        @(negedge iCLK);
        iLOAD  = 1'b1;
        iVALUE = v;
        iDP    = dp;
        @(posedge iCLK);
        #1;
        iLOAD = 1'b0;
    endtask

    task automatic waitDone(output int cyc);
        cyc = 0;
        while (oDONE !== 1'b1 && cyc < 100) begin
            @(posedge iCLK);
            #1;
            cyc++;
        end
    endtask

    task automatic test_reset;
        nRST = 1'b0;
        repeat (2) @(posedge iCLK);
        #1;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (seg[i] !== 8'h00) begin
                errors++;
                $display("FAIL reset_seg%0d got %h want 00", i, seg[i]);
            end
        end
        checks++;
        if (oBUSY !== 1'b0 || oDONE !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got busy=%b done=%b want 0 0", oBUSY, oDONE);
        end
        @(negedge iCLK);
        nRST = 1'b1;
    endtask

    task automatic test_normal;
        int cyc;
        loadVal(W'(12_345_678), 8'h00);
        checks++;
        if (oBUSY !== 1'b1) begin
            errors++;
            $display("FAIL normal_busy got %b want 1", oBUSY);
        end
        waitDone(cyc);
        checks++;
        if (cyc != 28) begin
            errors++;
            $display("FAIL normal_latency got %0d want 28", cyc);
        end
        checks++;
        if (oBUSY !== 1'b0) begin
            errors++;
            $display("FAIL normal_busy_end got %b want 0", oBUSY);
        end
        exp = '{8'hFE, 8'hE0, 8'hBE, 8'hB6, 8'h66, 8'hF2, 8'hDA, 8'h60};
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (seg[i] !== exp[i]) begin
                errors++;
                $display("FAIL normal_seg%0d got %h want %h", i, seg[i], exp[i]);
            end
        end
        @(posedge iCLK);
        #1;
        checks++;
        if (oDONE !== 1'b0) begin
            errors++;
            $display("FAIL normal_done_pulse got %b want 0", oDONE);
        end
    endtask

    task automatic test_zero;
        int cyc;
        loadVal(W'(0), 8'h00);
        waitDone(cyc);
        for (int i = 0; i < 8; i++) begin
            exp[i] = (i == 0) ? 8'hFC : lead(8'hFC);
            checks++;
            if (seg[i] !== exp[i]) begin
                errors++;
                $display("FAIL zero_seg%0d got %h want %h", i, seg[i], exp[i]);
            end
        end
    endtask

    task automatic test_overflow;
        int cyc;
        loadVal(W'(100_000_000), 8'hFF);
        waitDone(cyc);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (seg[i] !== 8'b0000_0010) begin
                errors++;
                $display("FAIL ovf_seg%0d got %h want 02", i, seg[i]);
            end
        end
        loadVal(W'(99_999_999), 8'hFF);
        waitDone(cyc);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (seg[i] !== 8'b1111_0111) begin
                errors++;
                $display("FAIL max_seg%0d got %h want f7", i, seg[i]);
            end
        end
    endtask

    task automatic test_decimal_point;
        int cyc;
        loadVal(W'(305), 8'b0000_0100);
        waitDone(cyc);
        exp = '{8'hB6, 8'hFC, 8'hF3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        for (int i = 3; i < 8; i++) exp[i] = lead(8'hFC);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (seg[i] !== exp[i]) begin
                errors++;
                $display("FAIL dp_seg%0d got %h want %h", i, seg[i], exp[i]);
            end
        end
    endtask

    task automatic test_load_while_busy;
        logic [7:0] prior [8];
        int  cyc = 0;
        int  dones;
        bit  held = 1'b1;
        for (int i = 0; i < 8; i++) prior[i] = seg[i];
        loadVal(W'(42), 8'h00);
        while (oDONE !== 1'b1 && cyc < 100) begin
            for (int i = 0; i < 8; i++) if (seg[i] !== prior[i]) held = 1'b0;
            if (cyc == 5) begin
                @(negedge iCLK);
                iLOAD  = 1'b1;
                iVALUE = W'(77);
            end
            @(posedge iCLK);
            #1;
            iLOAD = 1'b0;
            cyc++;
        end
        checks++;
        if (held !== 1'b1) begin
            errors++;
            $display("FAIL busy_hold got changed want held");
        end
        checks++;
        if (cyc != 28) begin
            errors++;
            $display("FAIL busy_latency got %0d want 28", cyc);
        end
        dones = (oDONE === 1'b1) ? 1 : 0;
        repeat (40) begin
            @(posedge iCLK);
            #1;
            if (oDONE === 1'b1) dones++;
        end
        checks++;
        if (dones != 1) begin
            errors++;
            $display("FAIL busy_single_done got %0d want 1", dones);
        end
        for (int i = 2; i < 8; i++) exp[i] = lead(8'hFC);
        exp[1] = 8'h66;
        exp[0] = 8'hDA;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (seg[i] !== exp[i]) begin
                errors++;
                $display("FAIL busy_seg%0d got %h want %h", i, seg[i], exp[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        int cyc;
        loadVal(W'(7), 8'h00);
        repeat (27) @(posedge iCLK);
        #1;
        checks++;
        if (oBUSY !== 1'b1) begin
            errors++;
            $display("FAIL b2b_encode_busy got %b want 1", oBUSY);
        end
        @(negedge iCLK);
        iLOAD  = 1'b1;
        iVALUE = W'(3);
        @(posedge iCLK);
        #1;
        iLOAD = 1'b0;
        checks++;
        if (oDONE !== 1'b1 || oBUSY !== 1'b0) begin
            errors++;
            $display("FAIL b2b_encode_load got done=%b busy=%b want 1 0", oDONE, oBUSY);
        end
        checks++;
        if (oSEG0 !== 8'hE0) begin
            errors++;
            $display("FAIL b2b_first_seg0 got %h want e0", oSEG0);
        end
        loadVal(W'(8), 8'h00);
        checks++;
        if (oBUSY !== 1'b1) begin
            errors++;
            $display("FAIL b2b_next_accept got %b want 1", oBUSY);
        end
        waitDone(cyc);
        checks++;
        if (cyc != 28 || oSEG0 !== 8'hFE) begin
            errors++;
            $display("FAIL b2b_second got cyc=%0d seg0=%h want 28 fe", cyc, oSEG0);
        end
    endtask

    task automatic test_reset_mid_run;
        int cyc;
        int dones = 0;
        loadVal(W'(555), 8'h00);
        repeat (10) @(posedge iCLK);
        #1;
        nRST = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (seg[i] !== 8'h00) begin
                errors++;
                $display("FAIL midrst_seg%0d got %h want 00", i, seg[i]);
            end
        end
        checks++;
        if (oBUSY !== 1'b0) begin
            errors++;
            $display("FAIL midrst_busy got %b want 0", oBUSY);
        end
        repeat (3) @(posedge iCLK);
        @(negedge iCLK);
        nRST = 1'b1;
        repeat (35) begin
            @(posedge iCLK);
            #1;
            if (oDONE === 1'b1) dones++;
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("FAIL midrst_no_done got %0d want 0", dones);
        end
        loadVal(W'(9), 8'h00);
        waitDone(cyc);
        checks++;
        if (cyc != 28) begin
            errors++;
            $display("FAIL midrst_latency got %0d want 28", cyc);
        end
        for (int i = 0; i < 8; i++) begin
            exp[i] = (i == 0) ? 8'hF6 : lead(8'hFC);
            checks++;
            if (seg[i] !== exp[i]) begin
                errors++;
                $display("FAIL midrst_seg%0d got %h want %h", i, seg[i], exp[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_zero();
        test_overflow();
        test_decimal_point();
        test_load_while_busy();
        test_back_to_back();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
